// File: rtl/line_draw_arbiter_if.sv
// line_draw_arbiter_if: requester bus, LCD controller handshake and latched job.
// The slave modport is the arbiter; master is the game-logic/controller side.
interface line_draw_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 16
);
  logic                       ctrlIdle;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*X_W-1:0]     reqX0;
  logic [NUM_REQ*Y_W-1:0]     reqY0;
  logic [NUM_REQ*X_W-1:0]     reqX1;
  logic [NUM_REQ*Y_W-1:0]     reqY1;
  logic [NUM_REQ*COLOR_W-1:0] reqColor;
  logic                       doneLine;
  logic                       goLine;
  logic [X_W-1:0]             lineX0;
  logic [Y_W-1:0]             lineY0;
  logic [X_W-1:0]             lineX1;
  logic [Y_W-1:0]             lineY1;
  logic [COLOR_W-1:0]         lineColor;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         ack;
  logic                       busy;
  logic                       wdogErr;

  modport slave (
    input  ctrlIdle, req, reqX0, reqY0, reqX1, reqY1, reqColor, doneLine,
    output goLine, lineX0, lineY0, lineX1, lineY1, lineColor, grant, ack, busy, wdogErr
  );

  modport master (
    output ctrlIdle, req, reqX0, reqY0, reqX1, reqY1, reqColor, doneLine,
    input  goLine, lineX0, lineY0, lineX1, lineY1, lineColor, grant, ack, busy, wdogErr
  );
endinterface

// File: rtl/line_draw_arbiter.sv
// line_draw_arbiter: round-robin sharing of the single line engine among
// NUM_REQ requesters. Optional macro LINE_WDOG_EN adds a DRAW-state watchdog
// that forces completion after WDOG_CYCLES cycles and sets a sticky wdogErr.
//
// state  | meaning
// IDLE   | wait for a request while the controller reports idle
// ARB    | pick round-robin winner, latch its job and grant
// LAUNCH | one-cycle goLine to the controller
// DRAW   | wait for doneLine (or watchdog timeout)
// ACK    | one-cycle ack to the owner, advance the round-robin pointer
module line_draw_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int COLOR_W     = 16,
  parameter int WDOG_CYCLES = 65535
) (
  input logic                clk_i,
  input logic                rst_i,
  line_draw_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
    $error("line_draw_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LAUNCH, S_DRAW, S_ACK} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d, win_idx;
  logic               win_vld;
  logic [X_W-1:0]     x0_q, x0_d, x1_q, x1_d;
  logic [Y_W-1:0]     y0_q, y0_d, y1_q, y1_d;
  logic [COLOR_W-1:0] col_q, col_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
  logic               go_q, go_d, busy_q, busy_d;
  logic               wdog_fire;

  // Round-robin search: lowest offset from rr_ptr_q with req set wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    col_d    = col_q;
    grant_d  = grant_q;
    ack_d    = '0;
    go_d     = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.ctrlIdle && (|bus.req)) state_d = S_ARB;
      S_ARB: begin
        if (win_vld) begin
          state_d = S_LAUNCH;
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          x0_d    = bus.reqX0[int'(win_idx) * X_W +: X_W];
          y0_d    = bus.reqY0[int'(win_idx) * Y_W +: Y_W];
          x1_d    = bus.reqX1[int'(win_idx) * X_W +: X_W];
          y1_d    = bus.reqY1[int'(win_idx) * Y_W +: Y_W];
          col_d   = bus.reqColor[int'(win_idx) * COLOR_W +: COLOR_W];
          go_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      S_LAUNCH: state_d = S_DRAW;
      S_DRAW: begin
        if (bus.doneLine || wdog_fire) begin
          state_d = S_ACK;
          grant_d = '0;
          ack_d   = NUM_REQ'(1) << owner_q;
        end
      end
      S_ACK: begin
        state_d  = S_IDLE;
        rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything including a live job.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      col_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      col_q    <= col_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
    end
  end

`ifdef LINE_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_err_q, wdog_err_d;

  assign wdog_fire = (state_q == S_DRAW) && (wdog_q == '0);

  // Reload on LAUNCH, count down through DRAW; a timeout without doneLine is sticky.
  always_comb begin
    wdog_d     = wdog_q;
    wdog_err_d = wdog_err_q;
    if (state_q == S_LAUNCH) wdog_d = WDOG_W'(WDOG_CYCLES);
    else if (state_q == S_DRAW && wdog_q != '0) wdog_d = wdog_q - 1'b1;
    if (wdog_fire && !bus.doneLine) wdog_err_d = 1'b1;
  end

  // Watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign bus.wdogErr = wdog_err_q;
`else
  assign wdog_fire   = 1'b0;
  assign bus.wdogErr = 1'b0;
`endif

  assign bus.goLine    = go_q;
  assign bus.lineX0    = x0_q;
  assign bus.lineY0    = y0_q;
  assign bus.lineX1    = x1_q;
  assign bus.lineY1    = y1_q;
  assign bus.lineColor = col_q;
  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_line_draw_arbiter.sv
// tb_line_draw_arbiter: directed + randomized jobs checked against a
// transaction-level round-robin model (pointer, winner, latched job, timing).
module tb_line_draw_arbiter;
  localparam int N  = 4;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_draw_arbiter_if #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) ifc ();

  line_draw_arbiter #(
    .NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .WDOG_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (ifc)
  );

  logic [N-1:0]  req_v = '0;
  logic          ctrl_idle = 1'b0;
  logic          done_v = 1'b0;
  logic [XW-1:0] x0 [N];
  logic [XW-1:0] x1 [N];
  logic [YW-1:0] y0 [N];
  logic [YW-1:0] y1 [N];
  logic [CW-1:0] col [N];

  always_comb begin
    ifc.req      = req_v;
    ifc.ctrlIdle = ctrl_idle;
    ifc.doneLine = done_v;
    ifc.reqX0    = '0;
    ifc.reqY0    = '0;
    ifc.reqX1    = '0;
    ifc.reqY1    = '0;
    ifc.reqColor = '0;
    for (int i = 0; i < N; i++) begin
      ifc.reqX0[i*XW +: XW]    = x0[i];
      ifc.reqY0[i*YW +: YW]    = y0[i];
      ifc.reqX1[i*XW +: XW]    = x1[i];
      ifc.reqY1[i*YW +: YW]    = y1[i];
      ifc.reqColor[i*CW +: CW] = col[i];
    end
  end

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  logic exp_wdog = 1'b0;
  logic [XW-1:0] e_x0, e_x1;
  logic [YW-1:0] e_y0, e_y1;
  logic [CW-1:0] e_col;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic rand_coords();
    for (int i = 0; i < N; i++) begin
      x0[i] = XW'($urandom); y0[i] = YW'($urandom);
      x1[i] = XW'($urandom); y1[i] = YW'($urandom);
      col[i] = CW'($urandom);
    end
  endtask

  task automatic chk_job(input string tag);
    chk({tag, "_x0"}, 32'(ifc.lineX0), 32'(e_x0));
    chk({tag, "_y0"}, 32'(ifc.lineY0), 32'(e_y0));
    chk({tag, "_x1"}, 32'(ifc.lineX1), 32'(e_x1));
    chk({tag, "_y1"}, 32'(ifc.lineY1), 32'(e_y1));
    chk({tag, "_col"}, 32'(ifc.lineColor), 32'(e_col));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_go"}, 32'(ifc.goLine), 0);
    chk({tag, "_grant"}, 32'(ifc.grant), 0);
    chk({tag, "_ack"}, 32'(ifc.ack), 0);
    chk({tag, "_busy"}, 32'(ifc.busy), 0);
    chk({tag, "_wdog"}, 32'(ifc.wdogErr), 0);
    e_x0 = '0; e_y0 = '0; e_x1 = '0; e_y1 = '0; e_col = '0;
    chk_job(tag);
  endtask

  // Entered in an IDLE cycle with req/ctrlIdle already driven; leaves in the following IDLE cycle.
  task automatic do_job(input int draw_len, input bit new_coords, input bit drop_req,
                        input bit drop_idle, input bit done_in_launch, input bit release_after,
                        output int own);
    logic [N-1:0] oh;
    if (new_coords) rand_coords();
    own = rr_pick(req_v, m_ptr);
    oh = N'(1) << own;
    e_x0 = x0[own]; e_y0 = y0[own]; e_x1 = x1[own]; e_y1 = y1[own]; e_col = col[own];
    tick();
    chk("arb_go", 32'(ifc.goLine), 0);
    chk("arb_busy", 32'(ifc.busy), 1);
    tick();
    chk("launch_go", 32'(ifc.goLine), 1);
    chk("launch_grant", 32'(ifc.grant), 32'(oh));
    chk_job("launch");
    if (done_in_launch) done_v = 1'b1;
    tick();
    done_v = 1'b0;
    chk("draw_go", 32'(ifc.goLine), 0);
    chk("draw_ack", 32'(ifc.ack), 0);
    rand_coords();
    if (drop_req) req_v[own] = 1'b0;
    if (drop_idle) ctrl_idle = 1'b0;
    for (int i = 0; i < draw_len; i++) begin
      tick();
      chk("draw_grant", 32'(ifc.grant), 32'(oh));
      chk("draw_ack", 32'(ifc.ack), 0);
      chk("draw_busy", 32'(ifc.busy), 1);
      chk_job("draw");
    end
    done_v = 1'b1;
    tick();
    done_v = 1'b0;
    chk("ack_pulse", 32'(ifc.ack), 32'(oh));
    chk("ack_grant", 32'(ifc.grant), 0);
    chk("ack_busy", 32'(ifc.busy), 1);
    chk("ack_wdog", 32'(ifc.wdogErr), 32'(exp_wdog));
    m_ptr = (own + 1) % N;
    ctrl_idle = 1'b1;
    if (release_after) req_v[own] = 1'b0;
    tick();
    chk("idle_ack", 32'(ifc.ack), 0);
    chk("idle_busy", 32'(ifc.busy), 0);
    chk("idle_go", 32'(ifc.goLine), 0);
    chk_job("idle_hold");
  endtask

  initial begin
    int own;
    int exp_seq [6] = '{0, 1, 3, 0, 1, 3};
    for (int i = 0; i < N; i++) begin
      x0[i] = '0; y0[i] = '0; x1[i] = '0; y1[i] = '0; col[i] = '0;
    end

    // Reset state.
    rst = 1'b1; req_v = 4'b0001; ctrl_idle = 1'b1;
    tick(); tick();
    chk_all_zero("reset");

    // Single request with the reference job.
    x0[0] = 9'd10; y0[0] = 8'd20; x1[0] = 9'd100; y1[0] = 8'd200; col[0] = 16'hF800;
    rst = 1'b0;
    do_job(49, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, own);
    chk("single_owner", 32'(own), 0);

    // ctrlIdle low blocks the start.
    ctrl_idle = 1'b0; req_v = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("noidle_go", 32'(ifc.goLine), 0);
      chk("noidle_busy", 32'(ifc.busy), 0);
    end
    ctrl_idle = 1'b1;
    do_job(6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, own);
    chk("noidle_owner", 32'(own), 1);

    // Withdraw before ARB (controller busy), then withdraw during ARB.
    ctrl_idle = 1'b0; req_v = 4'b0100;
    tick();
    req_v = '0; ctrl_idle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_pre_grant", 32'(ifc.grant), 0);
      chk("wd_pre_busy", 32'(ifc.busy), 0);
    end
    req_v = 4'b0100;
    tick();
    req_v = '0;
    tick();
    chk("wd_arb_grant", 32'(ifc.grant), 0);
    chk("wd_arb_go", 32'(ifc.goLine), 0);
    chk("wd_arb_busy", 32'(ifc.busy), 0);
    tick();
    chk("wd_arb_go2", 32'(ifc.goLine), 0);

    // Drop after LAUNCH: job still completes.
    req_v = 4'b0100;
    do_job(5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, own);
    chk("wd_late_owner", 32'(own), 2);

    // Reset mid-DRAW.
    req_v = 4'b0010;
    tick(); tick(); tick(); tick();
    chk("pre_rst_busy", 32'(ifc.busy), 1);
    rst = 1'b1; req_v = '0;
    tick();
    chk_all_zero("mid_rst");
    rst = 1'b0; done_v = 1'b1;
    tick();
    done_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_ack", 32'(ifc.ack), 0);
      chk("post_rst_go", 32'(ifc.goLine), 0);
    end
    m_ptr = 0;

    // Contention with requests held: pointer restarts at 0.
    req_v = 4'b1011;
    for (int j = 0; j < 6; j++) begin
      do_job(int'($urandom_range(0, 8)), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, own);
      chk("contention_order", 32'(own), 32'(exp_seq[j]));
    end

    // Randomized traffic.
    req_v = N'($urandom_range(1, 15));
    for (int j = 0; j < 24; j++) begin
      do_job(int'($urandom_range(0, 12)), 1'b1, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, own);
      if ($urandom_range(0, 2) == 0) req_v = req_v | (N'(1) << $urandom_range(0, N - 1));
      if (req_v == '0) req_v = N'($urandom_range(1, 15));
    end

`ifdef LINE_WDOG_EN
    begin
      int cnt;
      rst = 1'b1; req_v = '0;
      tick();
      rst = 1'b0; m_ptr = 0; req_v = 4'b0001; cnt = -1;
      tick(); tick(); tick();
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (ifc.ack != '0) begin
          cnt = k;
          break;
        end
      end
      chk("wdog_latency", 32'(cnt), 17);
      chk("wdog_ack", 32'(ifc.ack), 1);
      chk("wdog_err", 32'(ifc.wdogErr), 1);
      m_ptr = 1; req_v = 4'b0010; exp_wdog = 1'b1;
      tick();
      do_job(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, own);
      chk("wdog_sticky", 32'(ifc.wdogErr), 1);
      rst = 1'b1;
      tick();
      exp_wdog = 1'b0;
      chk("wdog_rst", 32'(ifc.wdogErr), 0);
      rst = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
